// File: rtl/multicycle_ctrl.sv
// Multicycle ARM main control: Moore FSM sequencing fetch/decode/execute plus ALU and instruction decoders.
// Latency: one state per clock (MEMRD/MEMWR held WAIT_CYCLES+1 cycles); no backpressure, decoders are combinational.
// Backpressure: none beyond the fixed memory wait; enables are forced low while reset_n is asserted.
module multicycle_ctrl #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    output logic       next_pc,
    output logic       irwrite,
    output logic       regw,
    output logic       memw,
    output logic       branch,
    output logic       pcs,
    output logic       adrsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic [1:0] alucontrol,
    output logic [1:0] flagw,
    output logic [1:0] immsrc,
    output logic [1:0] regsrc,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_t     state, state_nxt;
    logic [3:0] wcnt, wcnt_nxt;
    logic       npc_raw, irw_raw, regw_raw, memw_raw, br_raw;
    logic       aluop;
    logic [3:0] cmd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
            wcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = FETCH;
        wcnt_nxt  = 4'd0;
        npc_raw   = 1'b0;
        irw_raw   = 1'b0;
        regw_raw  = 1'b0;
        memw_raw  = 1'b0;
        br_raw    = 1'b0;
        adrsrc    = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        resultsrc = 2'b00;
        aluop     = 1'b0;
        case (state)
            FETCH: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irw_raw   = 1'b1;
                npc_raw   = 1'b1;
                state_nxt = DECODE;
            end
            DECODE: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                case (op)
                    2'b00:   state_nxt = funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_nxt = MEMADR;
                    2'b10:   state_nxt = BRANCH;
                    default: state_nxt = FETCH;
                endcase
            end
            MEMADR: begin
                alusrcb   = 2'b01;
                state_nxt = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adrsrc = 1'b1;
                if (wcnt == WAIT_LAST) begin
                    state_nxt = MEMWB;
                end else begin
                    state_nxt = MEMRD;
                    wcnt_nxt  = wcnt + 4'd1;
                end
            end
            MEMWB: begin
                resultsrc = 2'b01;
                regw_raw  = 1'b1;
                state_nxt = FETCH;
            end
            MEMWR: begin
                adrsrc   = 1'b1;
                memw_raw = 1'b1;
                if (wcnt == WAIT_LAST) begin
                    state_nxt = FETCH;
                end else begin
                    state_nxt = MEMWR;
                    wcnt_nxt  = wcnt + 4'd1;
                end
            end
            EXECUTER: begin
                alusrcb   = 2'b00;
                aluop     = 1'b1;
                state_nxt = ALUWB;
            end
            EXECUTEI: begin
                alusrcb   = 2'b01;
                aluop     = 1'b1;
                state_nxt = ALUWB;
            end
            ALUWB: begin
                regw_raw  = 1'b1;
                state_nxt = FETCH;
            end
            BRANCH: begin
                alusrcb   = 2'b01;
                resultsrc = 2'b10;
                br_raw    = 1'b1;
                state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Enables are masked by reset_n so nothing fires while the core is held in reset.
    assign next_pc = npc_raw  & reset_n;
    assign irwrite = irw_raw  & reset_n;
    assign regw    = regw_raw & reset_n;
    assign memw    = memw_raw & reset_n;
    assign branch  = br_raw   & reset_n;
    assign pcs     = ((rd == 4'd15) & regw) | branch;

    assign cmd = funct[4:1];

    always_comb begin
        alucontrol = 2'b00;
        flagw      = 2'b00;
        if (aluop) begin
            case (cmd)
                4'b0100: alucontrol = 2'b00;
                4'b0010: alucontrol = 2'b01;
                4'b0000: alucontrol = 2'b10;
                4'b1100: alucontrol = 2'b11;
                default: alucontrol = 2'b00;
            endcase
            flagw[1] = funct[0];
            flagw[0] = funct[0] & ((cmd == 4'b0100) | (cmd == 4'b0010));
        end
    end

    assign immsrc  = op;
    assign regsrc  = {op == 2'b01, op == 2'b10};
    assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: expected state walk per instruction drives a per-cycle output check.
module tb_multicycle_ctrl;
    localparam int WC = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       next_pc, irwrite, regw, memw, branch, pcs, adrsrc, alusrca;
    logic [1:0] alusrcb, resultsrc, alucontrol, flagw, immsrc, regsrc;
    logic [3:0] state_o;

    multicycle_ctrl #(.WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .rd(rd),
        .next_pc(next_pc), .irwrite(irwrite), .regw(regw), .memw(memw),
        .branch(branch), .pcs(pcs), .adrsrc(adrsrc), .alusrca(alusrca),
        .alusrcb(alusrcb), .resultsrc(resultsrc), .alucontrol(alucontrol),
        .flagw(flagw), .immsrc(immsrc), .regsrc(regsrc), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int exp_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Length of the state walk an instruction takes, FETCH included.
    function automatic int seq_len(input logic [1:0] o, input logic [5:0] f);
        case (o)
            2'b00:   return 4;
            2'b01:   return f[0] ? (4 + WC + 1) : (3 + WC + 1);
            2'b10:   return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int seq_at(input logic [1:0] o, input logic [5:0] f, input int i);
        if (i == 0) return 0;
        if (i == 1) return 1;
        case (o)
            2'b00:   return (i == 2) ? (f[5] ? 7 : 6) : 8;
            2'b10:   return 9;
            2'b01: begin
                if (i == 2) return 2;
                if (i < 3 + WC + 1) return f[0] ? 3 : 5;
                return 4;
            end
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] alu_exp(input logic [5:0] f);
        logic [1:0] c;
        logic s;
        s = f[0];
        case (f[4:1])
            4'd4:    c = 2'd0;
            4'd2:    c = 2'd1;
            4'd0:    c = 2'd2;
            4'd12:   c = 2'd3;
            default: c = 2'd0;
        endcase
        return {c, s, s & (f[4:1] == 4'd4 || f[4:1] == 4'd2)};
    endfunction

    // Per-cycle compare against the output table for the expected state.
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() == 0) begin
                chk("queue_underrun", 1, 0);
            end else begin
                int s;
                int e_npc, e_irw, e_regw, e_memw, e_br, e_adr, e_asa, e_asb, e_rs, e_alu;
                logic [3:0] a;
                s = exp_q.pop_front();
                e_npc = 0; e_irw = 0; e_regw = 0; e_memw = 0; e_br = 0;
                e_adr = 0; e_asa = 0; e_asb = 0; e_rs = 0; e_alu = 0;
                case (s)
                    0: begin e_asa = 1; e_asb = 2; e_rs = 2; e_irw = 1; e_npc = 1; end
                    1: begin e_asa = 1; e_asb = 2; e_rs = 2; end
                    2: e_asb = 1;
                    3: e_adr = 1;
                    4: begin e_rs = 1; e_regw = 1; end
                    5: begin e_adr = 1; e_memw = 1; end
                    6: e_alu = 1;
                    7: begin e_asb = 1; e_alu = 1; end
                    8: e_regw = 1;
                    9: begin e_asb = 1; e_rs = 2; e_br = 1; end
                    default: ;
                endcase
                a = e_alu ? alu_exp(funct) : 4'd0;
                chk("state_o", state_o, s);
                chk("next_pc", next_pc, e_npc);
                chk("irwrite", irwrite, e_irw);
                chk("regw", regw, e_regw);
                chk("memw", memw, e_memw);
                chk("branch", branch, e_br);
                chk("pcs", pcs, e_br | (e_regw & int'(rd == 4'd15)));
                chk("adrsrc", adrsrc, e_adr);
                chk("alusrca", alusrca, e_asa);
                chk("alusrcb", alusrcb, e_asb);
                chk("resultsrc", resultsrc, e_rs);
                chk("alucontrol", alucontrol, a[3:2]);
                chk("flagw", flagw, a[1:0]);
                chk("immsrc", immsrc, op);
                chk("regsrc", regsrc, {op == 2'b01, op == 2'b10});
            end
        end
    end

    task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r);
        int n;
        op = o; funct = f; rd = r;
        n = seq_len(o, f);
        for (int i = 0; i < n; i++) exp_q.push_back(seq_at(o, f, i));
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] add_walk;
        logic [3:0]  av;
        reset_n = 1'b0; op = 2'b00; funct = 6'b001000; rd = 4'd3;

        // Model pinned against hand-worked walks and decodes.
        add_walk = {4'(seq_at(2'b00, 6'b001000, 0)), 4'(seq_at(2'b00, 6'b001000, 1)),
                    4'(seq_at(2'b00, 6'b001000, 2)), 4'(seq_at(2'b00, 6'b001000, 3))};
        chk("model_add_walk", add_walk, 16'h0168);
        chk("model_ldr_len", seq_len(2'b01, 6'b000001), 7);
        chk("model_str_len", seq_len(2'b01, 6'b000000), 6);
        chk("model_ldr_wb", seq_at(2'b01, 6'b000001, 6), 4);
        chk("model_undef_len", seq_len(2'b11, 6'b000000), 2);
        av = alu_exp(6'b100101);
        chk("model_subs_alu", av, 4'b0111);

        #12;
        chk("rst_state", state_o, 0);
        chk("rst_enables", {next_pc, irwrite, regw, memw, branch, pcs}, 0);
        chk("rst_muxes", {adrsrc, alusrca, alusrcb, resultsrc}, 6'b0_1_10_10);
        @(posedge clk); #1 reset_n = 1'b1;
        #1;
        chk("rel_fetch", {state_o, irwrite, next_pc}, {4'd0, 2'b11});

        // Reset asserted mid-EXECUTER.
        @(posedge clk); @(posedge clk); #1;
        chk("pre_rst_exec", state_o, 6);
        reset_n = 1'b0;
        #1;
        chk("midrst_state", state_o, 0);
        chk("midrst_enables", {next_pc, irwrite, regw, memw, branch, pcs}, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        #1;
        chk("rel2_fetch", {state_o, irwrite, next_pc}, {4'd0, 2'b11});

        chk_en = 1'b1;
        run_instr(2'b00, 6'b001000, 4'd3);
        run_instr(2'b00, 6'b100101, 4'd15);
        run_instr(2'b01, 6'b011001, 4'd7);
        run_instr(2'b01, 6'b011000, 4'd15);
        run_instr(2'b10, 6'b100000, 4'd0);
        run_instr(2'b11, 6'b000000, 4'd15);
        for (int k = 0; k < 300; k++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            run_instr(2'($urandom), 6'($urandom), r);
        end
        chk_en = 1'b0;
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
